mdu_sequencer: RTL and testbench

- Iterative multiply/divide unit with its sequencing FSM and HI/LO registers.
- Serves MULT/MULTU/DIV/DIVU and MTHI/MTLO for the CPU core; MFHI/MFLO read Hi/Lo directly.
- Sits beside the main ALU and is driven by the decode stage with Start/Op.
- Busy stalls the core; one radix-2 step per cycle, fixed latency.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_step.sv | 38 +++
 rtl/mdu_sequencer.sv | 148 ++++++++++++++
 tb/tb_mdu_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer and its step datapath.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int ITER      = MDU_WIDTH;

  // Op field (low two bits of Funct): bit 1 selects divide, bit 0 selects unsigned.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
// Multiply: acc = {partial_hi, multiplier}; add-if-LSB then shift right.
// Divide:   acc = {remainder, dividend/quotient}; shift left, restoring subtract.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  step_mode_e           mode,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_nxt
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  // Both step flavours are computed; mode picks which one updates the accumulator.
  // rem_sh keeps the bit shifted out of the remainder so divisors with the
  // MSB set still compare correctly; the difference then always fits WIDTH bits.
  always_comb begin
    addend  = acc[0] ? operand : {WIDTH{1'b0}};
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh[WIDTH-1:0] - operand;
    acc_nxt = '0;
    if (mode == STEP_MUL) begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end else if (rem_sh >= {1'b0, operand}) begin
      acc_nxt = {diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers and its sequencing FSM.
//
//   state | meaning
//   IDLE  | waiting for Start; MTHI/MTLO writes honoured here
//   CALC  | one radix-2 step per cycle, counter 0..ITER-1
//   FIX   | sign correction, Hi/Lo written at the end of this cycle
//   DONE  | Done (and DivZero if applicable) pulse, then back to IDLE
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWrite,
  input  logic             LoWrite,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER - 1);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               s_a, s_b, is_div, dz;

  logic               sgn_in, div_in;
  logic [WIDTH-1:0]   a_abs_in, b_abs_in;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, a_orig;
  step_mode_e         mode;

  assign mode = is_div ? STEP_DIV : STEP_MUL;

  // Multiplicand (mult) or divisor (div) is the fixed operand of every step.
  mdu_step #(.WIDTH(WIDTH)) u_step (
    .mode    (mode),
    .acc     (acc),
    .operand (is_div ? b_mag : a_mag),
    .acc_nxt (acc_step)
  );

  // Decode of the incoming op and operand magnitudes used at capture time.
  always_comb begin
    sgn_in   = (Op == OP_MULT) || (Op == OP_DIV);
    div_in   = (Op == OP_DIV) || (Op == OP_DIVU);
    a_abs_in = (sgn_in && A[WIDTH-1]) ? -A : A;
    b_abs_in = (sgn_in && B[WIDTH-1]) ? -B : B;
  end

  // Sign correction of the finished magnitude result; a_orig rebuilds the raw dividend.
  always_comb begin
    prod_fix = (s_a ^ s_b) ? -acc : acc;
    quot_fix = (s_a ^ s_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = s_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    a_orig   = s_a ? -a_mag : a_mag;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and Moore outputs.
  always_comb begin
    state_nxt = state;
    Busy      = (state != IDLE);
    Done      = 1'b0;
    DivZero   = 1'b0;
    case (state)
      IDLE: if (Start) state_nxt = CALC;
      CALC: if (cnt == LAST) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: begin
        Done      = 1'b1;
        DivZero   = dz;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration, result write-back and MTHI/MTLO.
  // The accumulator's lower half is seeded with the multiplier or dividend;
  // the upper half starts cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      acc    <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      s_a    <= 1'b0;
      s_b    <= 1'b0;
      is_div <= 1'b0;
      dz     <= 1'b0;
      Hi     <= '0;
      Lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            is_div <= div_in;
            s_a    <= sgn_in & A[WIDTH-1];
            s_b    <= sgn_in & B[WIDTH-1];
            a_mag  <= a_abs_in;
            b_mag  <= b_abs_in;
            cnt    <= '0;
            dz     <= 1'b0;
            acc    <= {{WIDTH{1'b0}}, (div_in ? a_abs_in : b_abs_in)};
          end else begin
            if (HiWrite) Hi <= A;
            if (LoWrite) Lo <= A;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          if (!is_div) begin
            Hi <= prod_fix[2*WIDTH-1:WIDTH];
            Lo <= prod_fix[WIDTH-1:0];
          end else if (b_mag == '0) begin
            Hi <= a_orig;
            Lo <= '1;
            dz <= 1'b1;
          end else begin
            Hi <= rem_fix;
            Lo <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start, HiWrite, LoWrite;
  logic [1:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  int checks   = 0;
  int failures = 0;

  mdu_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .Op      (Op),
    .A       (A),
    .B       (B),
    .HiWrite (HiWrite),
    .LoWrite (LoWrite),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic following the MIPS result rules.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    dz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == OP_MULTU) begin
      p  = {32'b0, a} * {32'b0, b};
      hi = p[63:32];
      lo = p[31:0];
    end else if (op == OP_MULT) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
      dz = 1'b1;
    end else if (op == OP_DIVU) begin
      lo = a / b;
      hi = a % b;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end
  endtask

  // Issue one op and follow it to completion; optionally pokes Start/HiWrite mid-run.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit interfere);
    logic [31:0] ehi, elo;
    logic        edz;
    int          e, bc;
    model(op, a, b, ehi, elo, edz);
    Op = op; A = a; B = b; Start = 1'b1;
    tick();
    Start = 1'b0;
    A = $urandom; B = $urandom; Op = 2'($urandom);
    e  = 0;
    bc = (Busy === 1'b1) ? 1 : 0;
    while (Done !== 1'b1 && e < 40) begin
      if (interfere && e == 4) begin
        Start = 1'b1; HiWrite = 1'b1; A = $urandom; B = $urandom;
      end else begin
        Start = 1'b0; HiWrite = 1'b0;
      end
      tick();
      e++;
      if (Busy === 1'b1) bc++;
    end
    Start = 1'b0; HiWrite = 1'b0;
    chk({tag, " latency"}, 64'(e), 64'd33);
    chk({tag, " busy_cycles"}, 64'(bc), 64'd34);
    chk({tag, " hi"}, 64'(Hi), 64'(ehi));
    chk({tag, " lo"}, 64'(Lo), 64'(elo));
    chk({tag, " divzero"}, 64'(DivZero), 64'(edz));
    tick();
    chk({tag, " idle_after"}, {61'd0, Busy, Done, DivZero}, 64'd0);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    reset = 1'b1; Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    Op = 2'b00; A = '0; B = '0;
    tick(); tick();
    chk("reset_flags", {61'd0, Busy, Done, DivZero}, 64'd0);
    chk("reset_hilo", {Hi, Lo}, 64'd0);
    reset = 1'b0;
    tick();

    // MTHI/MTLO in idle, both strobes together
    A = 32'h1357_9BDF; HiWrite = 1'b1; LoWrite = 1'b1;
    tick();
    HiWrite = 1'b0; LoWrite = 1'b0;
    chk("mt_both", {Hi, Lo}, {32'h1357_9BDF, 32'h1357_9BDF});

    do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_max_exact", {Hi, Lo}, {32'hFFFF_FFFE, 32'h0000_0001});
    do_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    chk("mult_neg_exact", {Hi, Lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_neg_exact", {Hi, Lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op("divu_same", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("divu_same_exact", {Hi, Lo}, {32'h0000_0001, 32'h7FFF_FFFC});
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf_exact", {Hi, Lo}, {32'h0000_0000, 32'h8000_0000});
    do_op("divu_zero", OP_DIVU, 32'h0000_1234, 32'd0, 1'b0);
    chk("divu_zero_exact", {Hi, Lo}, {32'h0000_1234, 32'hFFFF_FFFF});
    do_op("div_zero_neg", OP_DIV, 32'h8765_4321, 32'd0, 1'b0);
    do_op("divu_bigdiv", OP_DIVU, 32'hFFFF_FFF0, 32'h8000_0001, 1'b0);

    // Start and HiWrite during Busy are ignored; next op follows straight after
    do_op("interfere", OP_MULT, 32'h0001_2345, 32'hFFFF_0100, 1'b1);
    do_op("back2back", OP_DIV, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    // Randomized ops against the reference model
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 300));
        2:       rb = -32'($urandom_range(1, 300));
        default: rb = $urandom;
      endcase
      do_op($sformatf("rand%0d", i), rop, ra, rb, 1'b0);
    end

    // Reset mid-operation, then MTHI/MTLO recover
    Op = OP_MULTU; A = 32'hFFFF_FFFF; B = 32'h1234_5678; Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    #3 reset = 1'b1;
    #1;
    chk("midrst_flags", {61'd0, Busy, Done, DivZero}, 64'd0);
    chk("midrst_hilo", {Hi, Lo}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    A = 32'h1111_2222; HiWrite = 1'b1;
    tick();
    HiWrite = 1'b0;
    A = 32'hCAFE_BABE; LoWrite = 1'b1;
    tick();
    LoWrite = 1'b0;
    chk("mtlo_after_rst", {Hi, Lo}, {32'h1111_2222, 32'hCAFE_BABE});
    chk("idle_after_rst", 64'(Busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
